// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, waits for a stable lock, and
// holds the downstream logic in reset until the PLL output clocks can be trusted.
// Retries a bounded number of times, then parks in FAIL until asked to retry.
module pll_lock_supervisor #(
    parameter int POR_CYCLES          = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       retry_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    // One shared counter must cover the longest of the three timed phases.
    localparam int MAX_AB  = (POR_CYCLES > LOCK_TIMEOUT_CYCLES) ? POR_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CNT = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] POR_LAST    = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [2:0]       RETRY_LIMIT = 3'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sync_q;
    logic [2:0]       retry_cnt_q, retry_cnt_d;
    logic [7:0]       lock_loss_q, lock_loss_d;
    logic             pll_rst_q, sys_rst_n_q, ready_q, fail_q;
    logic             locked_s;

    // Second synchronizer stage is the only view of lock the FSM ever uses.
    assign locked_s = sync_q[1];

    // Next-state, counter and statistics decisions.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        retry_cnt_d = retry_cnt_q;
        lock_loss_d = lock_loss_q;
        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == POR_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // A lock seen on the timeout cycle takes priority over the retry.
                if (locked_s) begin
                    state_d = S_STABILIZE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_cnt_q == RETRY_LIMIT) begin
                        state_d = S_FAIL;
                    end else begin
                        retry_cnt_d = retry_cnt_q + 3'd1;
                        state_d     = S_RESET_PLL;
                    end
                end
            end
            S_STABILIZE: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d     = S_RUN;
                    retry_cnt_d = 3'd0;
                end
            end
            S_RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    if (lock_loss_q != 8'hFF) lock_loss_d = lock_loss_q + 8'd1;
                end
            end
            S_FAIL: begin
                cnt_d = '0;
                if (retry_req) begin
                    state_d     = S_RESET_PLL;
                    retry_cnt_d = 3'd0;
                end
            end
            default: begin
                state_d = S_RESET_PLL;
            end
        endcase
        // Every phase starts timing from zero.
        if (state_d != state_q) cnt_d = '0;
    end

    // State, synchronizer and output flops; outputs are decoded from the
    // next state so every output pin comes straight off a flop.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET_PLL;
            cnt_q       <= '0;
            sync_q      <= 2'b00;
            retry_cnt_q <= 3'd0;
            lock_loss_q <= 8'd0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= {sync_q[0], locked};
            retry_cnt_q <= retry_cnt_d;
            lock_loss_q <= lock_loss_d;
            pll_rst_q   <= (state_d == S_RESET_PLL) || (state_d == S_FAIL);
            sys_rst_n_q <= (state_d == S_RUN);
            ready_q     <= (state_d == S_RUN);
            fail_q      <= (state_d == S_FAIL);
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst_n     = sys_rst_n_q;
    assign ready         = ready_q;
    assign fail          = fail_q;
    assign retry_cnt     = retry_cnt_q;
    assign lock_loss_cnt = lock_loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: segment tables, hand-written
// corner sequences and randomized lock behaviour against a phase-level model.
module tb_pll_lock_supervisor;

    localparam int POR     = 4;
    localparam int TIMEOUT = 32;
    localparam int STABLE  = 8;
    localparam int MAXR    = 2;

    logic       refclk;
    logic       rst_n;
    logic       locked_pin;
    logic       retry_pin;
    logic       pll_rst, sys_rst_n, ready, fail;
    logic [2:0] retry_cnt;
    logic [7:0] lock_loss_cnt;
    logic [14:0] dut_vec;

    pll_lock_supervisor #(
        .POR_CYCLES(POR),
        .LOCK_TIMEOUT_CYCLES(TIMEOUT),
        .LOCK_STABLE_CYCLES(STABLE),
        .MAX_RETRIES(MAXR)
    ) dut (
        .refclk(refclk),
        .rst_n(rst_n),
        .locked(locked_pin),
        .retry_req(retry_pin),
        .pll_rst(pll_rst),
        .sys_rst_n(sys_rst_n),
        .ready(ready),
        .fail(fail),
        .retry_cnt(retry_cnt),
        .lock_loss_cnt(lock_loss_cnt)
    );

    assign dut_vec = {pll_rst, sys_rst_n, ready, fail, retry_cnt, lock_loss_cnt};

    initial refclk = 1'b0;
    always #10 refclk = ~refclk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    localparam logic [14:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0};

    // ---------------- reference model ----------------
    typedef enum int {M_POR, M_WAIT, M_STAB, M_RUN, M_FAIL} mode_t;
    mode_t m_mode;
    int    m_age;
    int    m_retries;
    int    m_losses;
    bit    m_dly [0:1];   // [0] = pin one edge ago, [1] = pin two edges ago

    function automatic void model_reset();
        m_mode    = M_POR;
        m_age     = 0;
        m_retries = 0;
        m_losses  = 0;
        m_dly[0]  = 1'b0;
        m_dly[1]  = 1'b0;
    endfunction

    function automatic void model_enter(mode_t m);
        m_mode = m;
        m_age  = 0;
    endfunction

    // One refclk edge: decisions see the pin value from two edges earlier.
    function automatic void model_step(bit pin, bit req);
        bit ls;
        ls       = m_dly[1];
        m_dly[1] = m_dly[0];
        m_dly[0] = pin;
        case (m_mode)
            M_POR: begin
                m_age++;
                if (m_age == POR) model_enter(M_WAIT);
            end
            M_WAIT: begin
                if (ls) model_enter(M_STAB);
                else begin
                    m_age++;
                    if (m_age == TIMEOUT) begin
                        if (m_retries == MAXR) model_enter(M_FAIL);
                        else begin
                            m_retries++;
                            model_enter(M_POR);
                        end
                    end
                end
            end
            M_STAB: begin
                if (!ls) model_enter(M_WAIT);
                else begin
                    m_age++;
                    if (m_age == STABLE) begin
                        m_retries = 0;
                        model_enter(M_RUN);
                    end
                end
            end
            M_RUN: begin
                if (!ls) begin
                    if (m_losses < 255) m_losses++;
                    model_enter(M_WAIT);
                end
            end
            default: begin
                if (req) begin
                    m_retries = 0;
                    model_enter(M_POR);
                end
            end
        endcase
    endfunction

    function automatic logic [14:0] model_vec();
        return {(m_mode == M_POR) || (m_mode == M_FAIL), m_mode == M_RUN, m_mode == M_RUN,
                m_mode == M_FAIL, 3'(m_retries), 8'(m_losses)};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance one cycle, step the model on the same edge, compare at the falling edge.
    task automatic tick();
        @(posedge refclk);
        cyc++;
        if (rst_n) model_step(locked_pin, retry_pin);
        @(negedge refclk);
        check("model", {17'd0, dut_vec}, {17'd0, model_vec()});
    endtask

    // Assert reset between edges, confirm the outputs fall back immediately, then release.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("async_rst", {17'd0, dut_vec}, {17'd0, RST_VEC});
        model_reset();
        @(posedge refclk);
        @(negedge refclk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    typedef struct {
        bit         rst;
        bit         lk;
        bit         req;
        int         n;
        logic [6:0] exp;   // {pll_rst, sys_rst_n, ready, fail, retry_cnt}
    } vec_t;

    vec_t tbl [15];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bit saw;
        int flip_pct;

        // Clean bring-up, then a run with no lock at all.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 3,  7'b1000_000};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1,  7'b0000_000};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 6,  7'b0000_000};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 10, 7'b0000_000};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 5,  7'b0110_000};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 3,  7'b1000_000};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 32, 7'b0000_000};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 4,  7'b1000_001};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32, 7'b0000_001};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 4,  7'b1000_010};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32, 7'b0000_010};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 5,  7'b1001_010};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1,  7'b1000_000};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 3,  7'b1000_000};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1,  7'b0000_000};

        rst_n      = 1'b1;
        locked_pin = 1'b0;
        retry_pin  = 1'b0;
        model_reset();
        #5;

        for (int i = 0; i < 15; i++) begin
            locked_pin = tbl[i].lk;
            retry_pin  = 1'b0;
            if (tbl[i].rst) do_reset();
            retry_pin = tbl[i].req;
            for (int j = 0; j < tbl[i].n; j++) begin
                tick();
                check($sformatf("vec%0d", i), {25'd0, dut_vec[14:8]}, {25'd0, tbl[i].exp});
            end
        end
        retry_pin = 1'b0;

        // Lock glitch while stabilizing: the count must restart from scratch.
        locked_pin = 1'b0;
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            locked_pin = ((k >= 11) && (k <= 15)) || (k >= 17);
            tick();
            check("glitch", {25'd0, dut_vec[14:8]},
                  {25'd0, (k <= 3), (k >= 27), (k >= 27), 1'b0, 3'd0});
        end

        // Lock first visible exactly on the timeout cycle: lock wins.
        locked_pin = 1'b0;
        do_reset();
        for (int k = 1; k <= 45; k++) begin
            locked_pin = (k >= 34);
            tick();
            check("tie", {25'd0, dut_vec[14:8]},
                  {25'd0, (k <= 3), (k >= 44), (k >= 44), 1'b0, 3'd0});
        end

        // One cycle later the timeout wins and a retry starts.
        locked_pin = 1'b0;
        do_reset();
        for (int k = 1; k <= 36; k++) begin
            locked_pin = (k >= 35);
            tick();
        end
        check("tie_late", {25'd0, dut_vec[14:8]}, {25'd0, 7'b1000_001});

        // Repeated lock losses in RUN, counter saturating at 255.
        locked_pin = 1'b1;
        do_reset();
        guard = 0;
        while (!ready && guard < 100) begin tick(); guard++; end
        check("reach_run", {31'd0, ready}, 32'd1);
        for (int i = 0; i < 260; i++) begin
            locked_pin = 1'b0;
            saw = 1'b0;
            repeat (3) begin
                tick();
                if (!ready && !sys_rst_n) saw = 1'b1;
            end
            check("loss_drop", {31'd0, saw}, 32'd1);
            locked_pin = 1'b1;
            guard = 0;
            while (!ready && guard < 40) begin tick(); guard++; end
            check("loss_recover", {31'd0, ready}, 32'd1);
        end
        check("loss_sat", {24'd0, lock_loss_cnt}, 32'd255);

        // Reset during STABILIZE, then clean bring-up.
        locked_pin = 1'b1;
        do_reset();
        guard = 0;
        while (m_mode != M_STAB && guard < 50) begin tick(); guard++; end
        check("reach_stab", {31'd0, m_mode == M_STAB}, 32'd1);
        tick();
        tick();
        do_reset();
        guard = 0;
        while (!ready && guard < 100) begin tick(); guard++; end
        check("rerun_after_stab_rst", {31'd0, ready}, 32'd1);

        // Reset during FAIL, then clean bring-up.
        locked_pin = 1'b0;
        do_reset();
        guard = 0;
        while (!fail && guard < 300) begin tick(); guard++; end
        check("reach_fail", {31'd0, fail}, 32'd1);
        repeat (3) tick();
        do_reset();
        locked_pin = 1'b1;
        guard = 0;
        while (!ready && guard < 100) begin tick(); guard++; end
        check("rerun_after_fail_rst", {31'd0, ready}, 32'd1);

        // Randomized lock behaviour with stray retry requests and occasional resets.
        for (int r = 0; r < 6; r++) begin
            case (r)
                0: flip_pct = 2;
                1: flip_pct = 8;
                2: flip_pct = 20;
                3: flip_pct = 1;
                4: flip_pct = 5;
                default: flip_pct = 40;
            endcase
            locked_pin = 1'($urandom_range(0, 1));
            retry_pin  = 1'b0;
            do_reset();
            for (int t = 0; t < 600; t++) begin
                if ($urandom_range(0, 99) < flip_pct) locked_pin = ~locked_pin;
                retry_pin = ($urandom_range(0, 29) == 0);
                if ($urandom_range(0, 499) == 0) begin
                    retry_pin = 1'b0;
                    do_reset();
                end
                tick();
            end
        end
        retry_pin = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
